wrr_credit_arbiter: RTL and testbench

//   Weighted round-robin arbiter with per-channel credits and automatic round replenish.

---
 rtl/wrr_pkg.sv | 21 ++
 rtl/wrr_credit_arbiter_if.sv | 32 +++
 rtl/wrr_rr_pick.sv | 37 +++
 rtl/wrr_credit_arbiter.sv | 144 ++++++++++++++
 tb/tb_wrr_credit_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wrr_pkg.sv
// Shared types and helpers for the weighted round-robin credit arbiter.
// Holds FSM/mode encodings and the zero-weight rule.
package wrr_pkg;

    typedef enum logic [0:0] {
        ARB  = 1'b0,
        LOCK = 1'b1
    } wrr_state_e;

    typedef enum logic {
        MODE_RR  = 1'b0,
        MODE_WRR = 1'b1
    } wrr_mode_e;

    function automatic int unsigned eff_weight(
        input int unsigned w
    );
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/wrr_credit_arbiter_if.sv
// Request/grant bundle between the requesters and the arbiter.
// The master drives requests, the slave (arbiter) returns the grant.
interface wrr_credit_arbiter_if #(
    parameter int N = 8
) ();
    import wrr_pkg::*;

    localparam int IW = $clog2(N);

    logic [N-1:0]  i_req;
    logic [N-1:0]  i_last;
    logic [N-1:0]  o_gnt;
    logic [IW-1:0] o_gnt_idx;
    logic          o_gnt_vld;

    modport master (
        output i_req,
        output i_last,
        input  o_gnt,
        input  o_gnt_idx,
        input  o_gnt_vld
    );

    modport slave (
        input  i_req,
        input  i_last,
        output o_gnt,
        output o_gnt_idx,
        output o_gnt_vld
    );

endinterface

// File: rtl/wrr_rr_pick.sv
// Rotating-priority picker: first set bit of cand at or after ptr.
// Rotate down by ptr, isolate the lowest one, rotate back.
module wrr_rr_pick
    import wrr_pkg::*;
#(
    parameter  int N  = 8,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  cand,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [2*N-1:0] dbl_r;
    logic [2*N-1:0] dbl_b;
    logic [N-1:0]   rot;
    logic [N-1:0]   low;

    assign dbl_r = {cand, cand} >> ptr;
    assign rot   = dbl_r[N-1:0];
    assign low   = rot & (~rot + N'(1));
    assign dbl_b = {low, low} << ptr;
    assign gnt   = dbl_b[2*N-1:N];
    assign any   = |cand;

    always_comb begin
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) begin
                idx = idx | IW'(i);
            end
        end
    end

endmodule

// File: rtl/wrr_credit_arbiter.sv
// Weighted round-robin arbiter with per-channel credits,
// automatic round refill and packet-lock grants.
module wrr_credit_arbiter
    import wrr_pkg::*;
#(
    parameter int N       = 8,
    parameter int W       = 4,
    parameter bit LOCK_EN = 1'b1
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    input  logic                 i_en,
    input  logic                 i_mode,
    input  logic                 i_load,
    input  logic [N*W-1:0]       i_weights,
    output logic                 o_refill,
    wrr_credit_arbiter_if.slave  bus
);

    localparam int IW = $clog2(N);

    localparam logic [0:0] ST_ARB  = ARB;
    localparam logic [0:0] ST_LOCK = LOCK;

    logic [W-1:0]  w_q    [N];
    logic [W-1:0]  cred_q [N];
    logic [W-1:0]  eff    [N];
    logic [IW-1:0] ptr_q;
    logic [IW-1:0] k_q;
    logic [0:0]    state_q;
    logic [N-1:0]  gnt_q;
    logic [IW-1:0] idx_q;
    logic          vld_q;
    logic          refill_q;

    logic [N-1:0]  elig;
    logic [N-1:0]  cand;
    logic [N-1:0]  pgnt;
    logic [IW-1:0] pidx;
    logic          pany;
    logic          wrr;
    logic          refill;
    logic          hold;
    logic          take;

    always_comb begin
        elig = '0;
        for (int i = 0; i < N; i++) begin
            eff[i]  = W'(eff_weight(32'(w_q[i])));
            elig[i] = bus.i_req[i] && (cred_q[i] != '0);
        end
    end

    assign wrr    = (i_mode == MODE_WRR);
    assign refill = wrr && (elig == '0) && (bus.i_req != '0);
    assign cand   = (wrr && (elig != '0)) ? elig : bus.i_req;

    // Hold the current packet while its owner keeps requesting
    // without last; also re-assert it after an i_en gap.
    assign hold = LOCK_EN &&
        ((state_q == ST_LOCK && !vld_q) ||
         (vld_q && bus.i_req[k_q] && !bus.i_last[k_q]));

    assign take = i_en && !hold && pany;

    wrr_rr_pick #(
        .N (N)
    ) u_pick (
        .cand (cand),
        .ptr  (ptr_q),
        .gnt  (pgnt),
        .idx  (pidx),
        .any  (pany)
    );

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            gnt_q    <= '0;
            idx_q    <= '0;
            vld_q    <= 1'b0;
            refill_q <= 1'b0;
            ptr_q    <= '0;
            k_q      <= '0;
            state_q  <= ST_ARB;
        end else if (!i_en) begin
            gnt_q    <= '0;
            idx_q    <= '0;
            vld_q    <= 1'b0;
            refill_q <= 1'b0;
        end else if (hold) begin
            gnt_q    <= N'(1) << k_q;
            idx_q    <= k_q;
            vld_q    <= 1'b1;
            refill_q <= 1'b0;
            state_q  <= ST_LOCK;
        end else if (pany) begin
            gnt_q    <= pgnt;
            idx_q    <= pidx;
            vld_q    <= 1'b1;
            k_q      <= pidx;
            refill_q <= refill && !i_load;
            ptr_q    <= (pidx == IW'(N - 1)) ? '0 :
                        pidx + IW'(1);
            state_q  <= ST_ARB;
        end else begin
            gnt_q    <= '0;
            idx_q    <= '0;
            vld_q    <= 1'b0;
            refill_q <= 1'b0;
            state_q  <= ST_ARB;
        end
    end

    // A load overrides any same-cycle charge or refill.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            for (int i = 0; i < N; i++) begin
                w_q[i]    <= '0;
                cred_q[i] <= '0;
            end
        end else if (i_load) begin
            for (int i = 0; i < N; i++) begin
                w_q[i]    <= i_weights[i*W +: W];
                cred_q[i] <= i_weights[i*W +: W];
            end
        end else if (take && wrr) begin
            for (int i = 0; i < N; i++) begin
                if (refill) begin
                    cred_q[i] <= (IW'(i) == pidx) ?
                                 eff[i] - W'(1) : eff[i];
                end else if (IW'(i) == pidx &&
                             cred_q[i] != '0) begin
                    cred_q[i] <= cred_q[i] - W'(1);
                end
            end
        end
    end

    assign bus.o_gnt     = gnt_q;
    assign bus.o_gnt_idx = idx_q;
    assign bus.o_gnt_vld = vld_q;
    assign o_refill      = refill_q;

endmodule

// File: tb/tb_wrr_credit_arbiter.sv
// Directed bench for wrr_credit_arbiter at N=4, W=4, LOCK_EN=1.
// Each task drives one scenario and checks against hand values.
module tb_wrr_credit_arbiter;
    import wrr_pkg::*;

    logic        clk;
    logic        rstn;
    logic        en;
    logic        mode;
    logic        load;
    logic [15:0] weights;
    logic        refill;

    int checks;
    int errors;

    wrr_credit_arbiter_if #(.N(4)) bus ();

    wrr_credit_arbiter #(
        .N       (4),
        .W       (4),
        .LOCK_EN (1'b1)
    ) dut (
        .i_clk     (clk),
        .i_rstn    (rstn),
        .i_en      (en),
        .i_mode    (mode),
        .i_load    (load),
        .i_weights (weights),
        .o_refill  (refill),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn        = 1'b0;
        en          = 1'b1;
        mode        = 1'b0;
        load        = 1'b0;
        weights     = '0;
        bus.i_req   = '0;
        bus.i_last  = 4'hf;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.o_gnt !== 4'b0000) begin
            errors++;
            $display("FAIL reset_gnt got %b want 0000", bus.o_gnt);
        end
        checks++;
        if (bus.o_gnt_idx !== 2'd0) begin
            errors++;
            $display("FAIL reset_idx got %0d want 0", bus.o_gnt_idx);
        end
        checks++;
        if (bus.o_gnt_vld !== 1'b0 || refill !== 1'b0) begin
            errors++;
            $display("FAIL reset_vld_refill got %b%b want 00",
                     bus.o_gnt_vld, refill);
        end
        checks++;
        if (dut.ptr_q !== 2'd0 || dut.state_q !== 1'b0) begin
            errors++;
            $display("FAIL reset_ptr_state got %0d/%0d want 0/0",
                     dut.ptr_q, dut.state_q);
        end
    endtask

    task automatic test_rr();
        do_reset();
        mode       = 1'b0;
        bus.i_req  = 4'b1111;
        bus.i_last = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if (bus.o_gnt_idx !== 2'(i % 4) ||
                bus.o_gnt !== 4'(1 << (i % 4)) ||
                bus.o_gnt_vld !== 1'b1) begin
                errors++;
                $display("FAIL rr_seq[%0d] got %0d/%b want %0d",
                         i, bus.o_gnt_idx, bus.o_gnt, i % 4);
            end
        end
        bus.i_req = '0;
        step();
        checks++;
        if (bus.o_gnt_vld !== 1'b0) begin
            errors++;
            $display("FAIL rr_idle got %b want 0", bus.o_gnt_vld);
        end
    endtask

    task automatic test_wrr();
        int exp_idx [14] = '{0, 1, 2, 3, 0, 0, 1,
                             2, 3, 0, 0, 0, 1, 2};
        do_reset();
        mode    = 1'b1;
        weights = {4'd1, 4'd1, 4'd1, 4'd3};
        load    = 1'b1;
        step();
        load       = 1'b0;
        bus.i_req  = 4'b1111;
        bus.i_last = 4'b1111;
        for (int i = 0; i < 14; i++) begin
            step();
            checks++;
            if (bus.o_gnt_idx !== 2'(exp_idx[i]) ||
                bus.o_gnt_vld !== 1'b1) begin
                errors++;
                $display("FAIL wrr_seq[%0d] got %0d want %0d",
                         i, bus.o_gnt_idx, exp_idx[i]);
            end
            checks++;
            if (refill !== ((i == 6) || (i == 12))) begin
                errors++;
                $display("FAIL wrr_refill[%0d] got %b want %b",
                         i, refill, (i == 6) || (i == 12));
            end
        end
        bus.i_req = '0;
        step();
    endtask

    task automatic test_zero_weight();
        do_reset();
        mode    = 1'b1;
        weights = {4'd1, 4'd0, 4'd1, 4'd1};
        load    = 1'b1;
        step();
        load       = 1'b0;
        bus.i_req  = 4'b0100;
        bus.i_last = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (bus.o_gnt !== 4'b0100 || refill !== 1'b1) begin
                errors++;
                $display("FAIL zero_w[%0d] got %b/%b want 0100/1",
                         i, bus.o_gnt, refill);
            end
        end
        bus.i_req = '0;
        step();
    endtask

    task automatic test_lock();
        do_reset();
        mode    = 1'b1;
        weights = {4'd2, 4'd2, 4'd2, 4'd2};
        load    = 1'b1;
        step();
        load       = 1'b0;
        bus.i_req  = 4'b0001;
        bus.i_last = 4'b0001;
        step();
        bus.i_req  = 4'b1011;
        step();
        checks++;
        if (bus.o_gnt !== 4'b0010) begin
            errors++;
            $display("FAIL lock_first got %b want 0010", bus.o_gnt);
        end
        bus.i_last = 4'b0000;
        for (int b = 2; b <= 4; b++) begin
            step();
            checks++;
            if (bus.o_gnt !== 4'b0010) begin
                errors++;
                $display("FAIL lock_beat%0d got %b want 0010",
                         b, bus.o_gnt);
            end
        end
        bus.i_last = 4'b0010;
        step();
        checks++;
        if (bus.o_gnt !== 4'b1000 || bus.o_gnt_idx !== 2'd3) begin
            errors++;
            $display("FAIL lock_next got %b/%0d want 1000/3",
                     bus.o_gnt, bus.o_gnt_idx);
        end
        checks++;
        if (dut.cred_q[1] !== 4'd1) begin
            errors++;
            $display("FAIL lock_credit got %0d want 1",
                     dut.cred_q[1]);
        end
        bus.i_req  = '0;
        bus.i_last = 4'b1111;
        step();
    endtask

    task automatic test_en_lock();
        do_reset();
        mode       = 1'b0;
        bus.i_req  = 4'b0010;
        bus.i_last = 4'b0000;
        step();
        step();
        checks++;
        if (bus.o_gnt !== 4'b0010 || dut.state_q !== 1'b1) begin
            errors++;
            $display("FAIL en_locked got %b/%0d want 0010/1",
                     bus.o_gnt, dut.state_q);
        end
        en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (bus.o_gnt !== 4'b0000 || bus.o_gnt_vld !== 1'b0) begin
                errors++;
                $display("FAIL en_off[%0d] got %b want 0000",
                         i, bus.o_gnt);
            end
        end
        en = 1'b1;
        step();
        checks++;
        if (bus.o_gnt !== 4'b0010 || bus.o_gnt_idx !== 2'd1) begin
            errors++;
            $display("FAIL en_resume got %b want 0010", bus.o_gnt);
        end
        bus.i_req  = '0;
        bus.i_last = 4'b1111;
        step();
    endtask

    task automatic test_load_same_cycle();
        do_reset();
        mode       = 1'b1;
        weights    = {4'd5, 4'd1, 4'd7, 4'd2};
        bus.i_req  = 4'b0001;
        bus.i_last = 4'b1111;
        load       = 1'b1;
        step();
        load = 1'b0;
        checks++;
        if (bus.o_gnt !== 4'b0001) begin
            errors++;
            $display("FAIL load_gnt got %b want 0001", bus.o_gnt);
        end
        checks++;
        if (dut.cred_q[0] !== 4'd2 || dut.cred_q[1] !== 4'd7 ||
            dut.cred_q[2] !== 4'd1 || dut.cred_q[3] !== 4'd5) begin
            errors++;
            $display("FAIL load_cred got %0d %0d %0d %0d want 2 7 1 5",
                     dut.cred_q[0], dut.cred_q[1],
                     dut.cred_q[2], dut.cred_q[3]);
        end
        step();
        checks++;
        if (dut.cred_q[0] !== 4'd1 || refill !== 1'b0) begin
            errors++;
            $display("FAIL load_charge got %0d/%b want 1/0",
                     dut.cred_q[0], refill);
        end
        bus.i_req = '0;
        step();
    endtask

    task automatic test_async_reset();
        do_reset();
        mode       = 1'b0;
        bus.i_req  = 4'b0010;
        bus.i_last = 4'b0000;
        step();
        step();
        #3;
        rstn = 1'b0;
        #1;
        checks++;
        if (bus.o_gnt !== 4'b0000 || bus.o_gnt_vld !== 1'b0) begin
            errors++;
            $display("FAIL async_gnt got %b want 0000", bus.o_gnt);
        end
        checks++;
        if (dut.ptr_q !== 2'd0 || dut.state_q !== 1'b0) begin
            errors++;
            $display("FAIL async_ptr_state got %0d/%0d want 0/0",
                     dut.ptr_q, dut.state_q);
        end
        #2;
        bus.i_req  = '0;
        bus.i_last = 4'b1111;
        rstn       = 1'b1;
        step();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_rr();
        test_wrr();
        test_zero_weight();
        test_lock();
        test_en_lock();
        test_load_same_cycle();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
